// File: rtl/timeout_arbiter.sv
// timeout_arbiter: round-robin ownership of one shared down-counting timeout timer.
// Defining TIMEOUT_STATUS_EN adds sticky per-requester timeout status with clear.
module timeout_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] req_cnt,
  input  logic [NUM_REQ-1:0]       done,
`ifdef TIMEOUT_STATUS_EN
  input  logic [NUM_REQ-1:0]       tmo_clr,
  output logic [NUM_REQ-1:0]       tmo_status,
`endif
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic [NUM_REQ-1:0]       timeout
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, RUN, EXPIRE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [NUM_REQ-1:0] grant_d, timeout_d;
  logic [NUM_REQ-1:0] owner_oh, pick_oh;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx, scan_idx;
  logic [CNT_W-1:0]   pick_raw, pick_load;
  logic [CNT_W-1:0]   load_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign load_arr[g] = req_cnt[g*CNT_W +: CNT_W];
  end

  // Scan from farthest to nearest so the requester just after the last owner wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      scan_idx = IDX_W'((int'(last_q) + k) % NUM_REQ);
      if (req[scan_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  assign pick_raw  = load_arr[pick_idx];
  assign pick_load = (pick_raw == '0) ? CNT_W'(1) : pick_raw;
  assign pick_oh   = NUM_REQ'(1) << pick_idx;
  assign owner_oh  = NUM_REQ'(1) << owner_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    last_d    = last_q;
    grant_d   = '0;
    timeout_d = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = RUN;
          cnt_d   = pick_load;
          owner_d = pick_idx;
          last_d  = pick_idx;
          grant_d = pick_oh;
        end
      end
      RUN: begin
        // A completion from the owner beats an expiry landing in the same cycle.
        if (done[owner_q]) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d   = EXPIRE;
          cnt_d     = cnt_q - CNT_W'(1);
          timeout_d = owner_oh;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          grant_d = owner_oh;
        end
      end
      EXPIRE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pointer resets to the last index so requester 0 is searched first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      grant   <= '0;
      timeout <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      grant   <= grant_d;
      timeout <= timeout_d;
    end
  end

  assign busy = |grant;

`ifdef TIMEOUT_STATUS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_status <= '0;
    end else begin
      tmo_status <= (tmo_status & ~tmo_clr) | timeout;
    end
  end
`endif

endmodule
